// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream select multiplexer.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED,
    MODE_RR,
    MODE_ZERO,
    MODE_HOLD
  } mux_mode_t;

  localparam int unsigned MUX_MAX_CH = 16;

endpackage : stream_mux_pkg

// File: rtl/stream_select_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo M.
module rr_arbiter #(
  parameter int unsigned M  = 3,
  parameter int unsigned SW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int unsigned      pos;
  logic [SW-1:0]    idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    idx       = '0;
    for (int unsigned k = 0; k < M; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= M) pos = pos - M;
      idx = SW'(pos);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_select_mux.sv
// Registered M-to-1 stream mux with fixed, round-robin, zero-fill and hold modes.
module stream_select_mux
  import stream_mux_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned M  = 3,
  parameter int unsigned SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  sel,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  grant_idx
);

  mux_mode_t      mode_e;
  logic           load_c;
  logic           arb_valid;
  logic [SW-1:0]  arb_idx;
  logic           cand_valid_c;
  logic [SW-1:0]  cand_idx_c;
  logic [N-1:0]   cand_data_c;
  logic [M-1:0]   in_ready_c;
  logic [N-1:0]   ch_data [M];

  logic [N-1:0]   out_data_q,  out_data_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  grant_q,     grant_d;
  logic [SW-1:0]  rr_ptr_q,    rr_ptr_d;

  assign mode_e = mux_mode_t'(mode);
  assign load_c = !out_valid_q || out_ready;

  for (genvar g = 0; g < M; g++) begin : g_ch
    assign ch_data[g] = in_data[g*N +: N];
  end

  rr_arbiter #(
    .M  (M),
    .SW (SW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Mode decode: pick the candidate channel and raise its ready when the register can load.
  always_comb begin
    cand_valid_c = 1'b0;
    cand_idx_c   = '0;
    in_ready_c   = '0;
    case (mode_e)
      MODE_FIXED: begin
        if (32'(sel) < M) begin
          cand_valid_c      = in_valid[sel];
          cand_idx_c        = sel;
          in_ready_c[sel]   = load_c;
        end
      end
      MODE_RR: begin
        cand_valid_c = arb_valid;
        cand_idx_c   = arb_idx;
        if (arb_valid) in_ready_c[arb_idx] = load_c;
      end
      default: ;
    endcase
    if (rst) in_ready_c = '0;
  end

  always_comb begin
    cand_data_c = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (cand_idx_c == SW'(i)) cand_data_c = ch_data[i];
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_c) begin
      case (mode_e)
        MODE_FIXED, MODE_RR: begin
          out_valid_d = cand_valid_c;
          if (cand_valid_c) begin
            out_data_d = cand_data_c;
            grant_d    = cand_idx_c;
          end
          if (mode_e == MODE_RR && cand_valid_c) begin
            rr_ptr_d = (arb_idx == SW'(M - 1)) ? '0 : arb_idx + SW'(1);
          end
        end
        MODE_ZERO: begin
          out_data_d  = '0;
          out_valid_d = 1'b1;
          grant_d     = '0;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_idx = grant_q;

endmodule : stream_select_mux

// File: tb/tb_stream_select_mux.sv
// Directed self-checking bench for stream_select_mux (N=16, M=3).
module tb_stream_select_mux;

  localparam int unsigned N  = 16;
  localparam int unsigned M  = 3;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     mode;
  logic [SW-1:0]  sel;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  grant_idx;

  int checks   = 0;
  int failures = 0;

  stream_select_mux #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; sel = 2'd0; in_valid = 3'b111; out_ready = 1'b1;
    in_data = {16'h000C, 16'h000B, 16'h000A};
    #1;
    checks++;
    if (in_ready !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b exp=000", in_ready);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h g=%0d exp v=0 d=0000 g=0", out_valid, out_data, grant_idx);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fixed();
    mode = 2'b00; sel = 2'd1; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b010) begin
      failures++; $display("FAIL fixed_ready got=%b exp=010", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h000B || grant_idx !== 2'd1) begin
        failures++;
        $display("FAIL fixed_beat%0d got v=%b d=%h g=%0d exp v=1 d=000b g=1", k, out_valid, out_data, grant_idx);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [M-1:0] exp_rdy;
    logic [N-1:0] exp_d;
    mode = 2'b01; in_valid = 3'b111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rdy = 3'(1 << (k % 3));
      exp_d   = 16'(16'h000A + (k % 3));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_ready%0d got=%b exp=%b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || grant_idx !== 2'(k % 3) || out_data !== exp_d) begin
        failures++;
        $display("FAIL rr_grant%0d got v=%b g=%0d d=%h exp v=1 g=%0d d=%h", k, out_valid, grant_idx, out_data, k % 3, exp_d);
      end
    end
  endtask

  task automatic test_rr_wrap();
    mode = 2'b01; in_valid = 3'b100; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b100) begin
      failures++; $display("FAIL wrap_ready2 got=%b exp=100", in_ready);
    end
    tick();
    checks++;
    if (grant_idx !== 2'd2 || out_data !== 16'h000C) begin
      failures++; $display("FAIL wrap_grant2 got g=%0d d=%h exp g=2 d=000c", grant_idx, out_data);
    end
    in_valid = 3'b101;
    #1;
    checks++;
    if (in_ready !== 3'b001) begin
      failures++; $display("FAIL wrap_ready0 got=%b exp=001", in_ready);
    end
    tick();
    checks++;
    if (grant_idx !== 2'd0 || out_data !== 16'h000A) begin
      failures++; $display("FAIL wrap_grant0 got g=%0d d=%h exp g=0 d=000a", grant_idx, out_data);
    end
  endtask

  task automatic test_backpressure();
    mode = 2'b00; sel = 2'd0; in_valid = 3'b111; out_ready = 1'b1;
    tick();
    in_data = {16'h000C, 16'h000B, 16'h1111};
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_ready !== 3'b000) begin
        failures++; $display("FAIL bp_ready%0d got=%b exp=000", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h000A || grant_idx !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b d=%h g=%0d exp v=1 d=000a g=0", k, out_valid, out_data, grant_idx);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b001) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
      failures++; $display("FAIL bp_beat1 got v=%b d=%h exp v=1 d=1111", out_valid, out_data);
    end
    in_data = {16'h000C, 16'h000B, 16'h2222};
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h2222) begin
      failures++; $display("FAIL bp_beat2 got v=%b d=%h exp v=1 d=2222", out_valid, out_data);
    end
    in_data = {16'h000C, 16'h000B, 16'h000A};
  endtask

  task automatic test_sel_out_of_range();
    mode = 2'b00; sel = 2'd3; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b000) begin
      failures++; $display("FAIL oob_ready got=%b exp=000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL oob_valid got=%b exp=0", out_valid);
    end
    sel = 2'd0;
  endtask

  task automatic test_zero_hold();
    mode = 2'b01; in_valid = 3'b111; out_ready = 1'b1;
    tick();
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 3'b000) begin
        failures++; $display("FAIL zero_ready%0d got=%b exp=000", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0000 || grant_idx !== 2'd0) begin
        failures++;
        $display("FAIL zero_beat%0d got v=%b d=%h g=%0d exp v=1 d=0000 g=0", k, out_valid, out_data, grant_idx);
      end
    end
    mode = 2'b11; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 3'b000) begin
      failures++; $display("FAIL hold_stall got v=%b r=%b exp v=1 r=000", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL hold_drain got v=%b exp v=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 3'b000) begin
      failures++; $display("FAIL hold_idle got v=%b r=%b exp v=0 r=000", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b01; in_valid = 3'b001; out_ready = 1'b1;
    tick();
    mode = 2'b00; sel = 2'd2; in_valid = 3'b111;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h000C || grant_idx !== 2'd2) begin
      failures++; $display("FAIL mid_preload got v=%b d=%h g=%0d exp v=1 d=000c g=2", out_valid, out_data, grant_idx);
    end
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%b d=%h g=%0d exp v=0 d=0000 g=0", out_valid, out_data, grant_idx);
    end
    mode = 2'b01; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b001) begin
      failures++; $display("FAIL mid_rr_ready got=%b exp=001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant_idx !== 2'd0 || out_data !== 16'h000A) begin
      failures++; $display("FAIL mid_rr_grant got v=%b g=%0d d=%h exp v=1 g=0 d=000a", out_valid, grant_idx, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_rr_wrap();
    test_backpressure();
    test_sel_out_of_range();
    test_zero_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stream_select_mux

// File: doc/stream_select_mux.md
# stream_select_mux

Registered, parametrised M-to-1 stream multiplexer with valid/ready handshakes on every channel and a one-stage output register. It generalises the fixed-select operand mux in the datapath, where one select code forces zero. It adds selectable fixed, round-robin and zero-fill modes and never drops or duplicates a beat under backpressure. It sits between the operand sources (BRAM readers, DMA streams) and the compute array input.

## Interface
- `N`, 16, data width in bits
- `M`, 3, number of input channels (2..16)
- `SW`, `$clog2(M)`, select width (derived, not overridden)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  00 FIXED, 01 ROUND_ROBIN, 10 ZERO_FILL, 11 HOLD
- `sel`  in  SW  channel index used in FIXED mode
- `in_data`  in  M×N  packed input channels; channel i at bits [i*N +: N]
- `in_valid`  in  M  per-channel valid
- `in_ready`  out  M  per-channel ready; at most one bit high per cycle
- `out_data`  out  N  registered output data
- `out_valid`  out  1  registered output valid
- `out_ready`  in  1  downstream ready
- `grant_idx`  out  SW  registered index of channel that produced current `out_data`; 0 in ZERO_FILL

## Operation
- Beat transfer on any port is defined as `valid && ready` at a rising edge.
- `load = !out_valid || out_ready`; the output register accepts a new beat only when `load` is 1.
- FIXED: candidate channel is `sel`.
  - `in_ready[sel] = load`; all other `in_ready` bits are 0.
  - A `sel >= M` selects nothing; all `in_ready` bits are 0 and no beat loads.
- ROUND_ROBIN: pointer `rr_ptr` (SW bits) resets to 0.
  - The candidate is the first `i` with `in_valid[i]`, searching from `rr_ptr` upward modulo M.
  - `in_ready[i] = load` for the candidate only.
  - On a transfer, `rr_ptr` becomes `(i+1) mod M`; with no transfer, `rr_ptr` holds.
- ZERO_FILL: all `in_ready` bits are 0; when `load`, the register takes `out_data = 0`, `out_valid = 1`, `grant_idx = 0`. No inputs are consumed.
- HOLD: all `in_ready` bits are 0. The output register still drains: `out_valid` clears on a transfer and is not refilled.
- Loading from a channel sets `out_data = in_data[i]`, `out_valid = 1`, `grant_idx = i`. If `load` is 1 and no candidate is valid, `out_valid` becomes 0.
- `mode` and `sel` are sampled every cycle and may change freely. A beat already in the output register is unaffected by such changes and keeps its value until accepted.
- `in_ready` is combinational from `mode`, `sel`, `in_valid`, `rr_ptr`, `out_valid`, `out_ready`. It does not depend on `in_data`.

## Timing
- Latency: 1 cycle, input transfer to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Reset values: `out_valid = 0`, `out_data = 0`, `grant_idx = 0`, `rr_ptr = 0`. `in_ready` is all 0 during the cycle `rst` is high.
- Reset mid-transfer: the pending output beat is discarded. Any input handshake in the reset cycle is not a transfer.
- Backpressure: while `out_valid && !out_ready`, the values `out_data` and `grant_idx` stay stable and all `in_ready` bits are 0.
- Simultaneous drain and fill: when `out_valid && out_ready` and a candidate is valid, the next beat loads in the same edge with no bubble.
- Round-robin wrap: a grant to channel M-1 moves `rr_ptr` to 0.
- Mode change between cycles takes effect on the next `load` with no extra delay. `rr_ptr` is retained across mode changes.

## Structure
- Package `stream_mux_pkg`:
  - `typedef enum logic [1:0] {MODE_FIXED, MODE_RR, MODE_ZERO, MODE_HOLD} mux_mode_t`
  - constant `MUX_MAX_CH = 16`
- Sub-module `rr_arbiter` (parameter M): inputs `req[M]`, `ptr`; outputs `gnt_valid`, `gnt_idx`. It is purely combinational.
- Top level: `rr_ptr` register, the output register, and the mode decode.

## Test plan
- Reset, then FIXED, `sel=1`, `in_valid=3'b111`, data {0x000A, 0x000B, 0x000C}, `out_ready=1` → `in_ready=3'b010`. One cycle later, `out_data=0x000B` and `grant_idx=1`, repeating every cycle.
- ROUND_ROBIN, all valid, `out_ready=1`, 6 cycles → `grant_idx` sequence 0,1,2,0,1,2.
- ROUND_ROBIN, only channel 2 valid, then channels 0 and 2 valid → grants 2 then 0 (pointer wrapped past 2).
- FIXED `sel=0`, `out_ready=0` for 4 cycles after the first beat → `out_data` stable, `in_ready=0`. Raising `out_ready` gives back-to-back beats with no bubble.
- ZERO_FILL with all inputs valid → `out_data=0x0000`, `out_valid=1`, `in_ready=0` every cycle. Switching to HOLD → `out_valid` clears after one accepted beat.
- Assert `rst` while `out_valid=1` and `out_ready=0` → next cycle `out_valid=0` and `out_data=0`. The following round-robin grant is channel 0.
